fir_ss_feeder: RTL and testbench

- Upstream stream source for the fir block; drives fir's ss_* AXI-Stream slave port.
- Reads a programmed number of samples from a sample BRAM (bram11-style, 1-cycle read latency) and emits them as an AXI-Stream with ss_tlast on the final beat.
- Sustains 1 beat/cycle under backpressure using a 2-entry output buffer; start/length/done are driven by the SoC control logic.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_skid_fifo2.sv | 53 +++++
 rtl/fir_ss_feeder.sv | 129 ++++++++++++
 tb/tb_fir_ss_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the fir sample feeder: controller states, word size
// and default bus widths.
package fir_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/fir_skid_fifo2.sv
// Two-entry FIFO carrying a sample plus its last-beat flag. The head entry is
// presented combinationally; outputs read as zero while the FIFO is empty.
module fir_skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_data [2];
  logic [1:0]   r_last;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_last[r_wr_ptr] <= i_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_data  = (r_count != 2'd0) ? r_data[r_rd_ptr] : '0;
  assign o_last  = (r_count != 2'd0) && r_last[r_rd_ptr];

endmodule

// File: rtl/fir_ss_feeder.sv
// Streams a programmed number of samples from the sample BRAM into the fir
// ss_* AXI-Stream port, one beat per cycle when the sink keeps up.
//
// state   | meaning
// IDLE    | waiting for start; stream and BRAM idle
// RUN     | issuing BRAM reads and emitting beats; busy high
// FINISH  | one cycle after the last beat (or a zero-length start); done high
module fir_ss_feeder
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
  parameter int pLEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  input  logic [pADDR_WIDTH-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   src_EN,
  output logic [3:0]             src_WE,
  output logic [pADDR_WIDTH-1:0] src_A,
  input  logic [pDATA_WIDTH-1:0] src_Do,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready
);

  feeder_state_e           r_state;
  feeder_state_e           w_state_nxt;
  logic [pLEN_WIDTH-1:0]   r_len;
  logic [pLEN_WIDTH-1:0]   r_rd_cnt;
  logic [pLEN_WIDTH-1:0]   r_out_cnt;
  logic [pADDR_WIDTH-1:0]  r_base;
  logic                    r_inflight;
  logic                    r_inflight_last;
  logic                    w_start_ok;
  logic                    w_issue;
  logic                    w_pop;
  logic                    w_last_beat;
  logic                    w_head_last;
  logic [pDATA_WIDTH-1:0]  w_head_data;
  logic [1:0]              w_fifo_count;
  logic [2:0]              w_occupancy;
  logic [pADDR_WIDTH-1:0]  w_addr;

  assign w_start_ok  = start && (r_state == ST_IDLE);
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign ss_tvalid   = (r_state == ST_RUN) && (w_fifo_count != 2'd0);
  assign w_pop       = ss_tvalid && ss_tready;
  assign w_last_beat = w_pop && (r_out_cnt == r_len - pLEN_WIDTH'(1));

  // A beat leaving this cycle frees a slot, so the slot can be re-filled by a
  // read issued in the same cycle; that is what keeps 1 beat/cycle.
  assign w_issue = (r_state == ST_RUN) && (r_rd_cnt < r_len) &&
                   (w_occupancy < (w_pop ? 3'd3 : 3'd2));
  assign w_addr  = r_base + pADDR_WIDTH'(r_rd_cnt * pLEN_WIDTH'(WORD_BYTES));

  assign src_EN    = w_issue;
  assign src_A     = w_issue ? w_addr : '0;
  assign src_WE    = 4'b0000;
  assign ss_tdata  = w_head_data;
  assign ss_tlast  = ss_tvalid && w_head_last;

  fir_skid_fifo2 #(.W(pDATA_WIDTH)) u_fifo (
    .clk     (axis_clk),
    .rst_n   (axis_rst_n),
    .i_push  (r_inflight),
    .i_data  (src_Do),
    .i_last  (r_inflight_last),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_last  (w_head_last),
    .o_count (w_fifo_count)
  );

  // State register, transfer parameters, counters and read-in-flight tracking.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_base          <= '0;
      r_rd_cnt        <= '0;
      r_out_cnt       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rd_cnt == r_len - pLEN_WIDTH'(1));
      if (w_start_ok) begin
        r_len     <= data_length;
        r_base    <= base_addr;
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_issue) r_rd_cnt  <= r_rd_cnt + pLEN_WIDTH'(1);
        if (w_pop)   r_out_cnt <= r_out_cnt + pLEN_WIDTH'(1);
      end
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (data_length != '0) ? ST_RUN : ST_FINISH;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last_beat) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_ss_feeder.sv
`timescale 1ns/1ps
module tb_fir_ss_feeder;

  logic        axis_clk    = 1'b0;
  logic        axis_rst_n  = 1'b0;
  logic        start       = 1'b0;
  logic [31:0] data_length = '0;
  logic [11:0] base_addr   = '0;
  logic        busy, done, src_EN, ss_tvalid, ss_tlast;
  logic [3:0]  src_WE;
  logic [11:0] src_A;
  logic [31:0] src_Do      = '0;
  logic [31:0] ss_tdata;
  logic        ss_tready   = 1'b0;

  int vec  = 0;
  int errs = 0;

  logic [31:0] mem [0:1023];
  logic [11:0] addr_log [$];

  always #5 axis_clk = ~axis_clk;

  fir_ss_feeder dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .start       (start),
    .data_length (data_length),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .src_EN      (src_EN),
    .src_WE      (src_WE),
    .src_A       (src_A),
    .src_Do      (src_Do),
    .ss_tvalid   (ss_tvalid),
    .ss_tdata    (ss_tdata),
    .ss_tlast    (ss_tlast),
    .ss_tready   (ss_tready)
  );

  // Sample BRAM model: one-cycle read latency; every issued address is logged.
  always @(posedge axis_clk) begin
    if (src_EN) begin
      src_Do <= mem[src_A[11:2]];
      addr_log.push_back(src_A);
    end
  end

  task automatic pulse_start(input logic [31:0] len, input logic [11:0] base);
    @(negedge axis_clk);
    start = 1'b1; data_length = len; base_addr = base;
    @(posedge axis_clk);
    #1;
    start = 1'b0; data_length = $urandom; base_addr = 12'($urandom);
  endtask

  task automatic test_reset();
    #3;
    vec++;
    if ({busy, done, src_EN, src_WE, src_A, ss_tvalid, ss_tdata, ss_tlast} !== '0) begin
      errs++;
      $display("FAIL reset_values: got busy=%b done=%b en=%b we=%h a=%h v=%b d=%h l=%b want all 0",
               busy, done, src_EN, src_WE, src_A, ss_tvalid, ss_tdata, ss_tlast);
    end
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
  // inj != 0: a second start (len 5, base 0x800) is pulsed in that cycle.
  task automatic test_stream(input string nm, input logic [11:0] base, input int len,
                             input int mode, input int inj);
    int          beat = 0;
    int          cyc = 0;
    int          budget;
    bit          done_seen = 0;
    bit          first_seen = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    logic [31:0] exp_d;
    logic        exp_l;
    logic [11:0] exp_a;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    budget = 4 * len + 40;
    addr_log.delete();
    pulse_start(32'(len), base);
    while (!done_seen && cyc < budget) begin
      @(negedge axis_clk);
      cyc++;
      if (cyc == inj) begin
        start = 1'b1; data_length = 32'd5; base_addr = 12'h800;
      end else begin
        start = 1'b0;
      end
      if (mode == 0)      ss_tready = 1'b1;
      else if (mode == 1) ss_tready = pat[cyc % 4];
      else                ss_tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        vec++;
        if (ss_tvalid !== 1'b1 || ss_tdata !== prev_d || ss_tlast !== prev_l) begin
          errs++;
          $display("FAIL %s stall_hold cyc %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   nm, cyc, ss_tvalid, ss_tdata, ss_tlast, prev_d, prev_l);
        end
      end
      if (ss_tvalid === 1'b1 && !first_seen) begin
        first_seen = 1;
        vec++;
        if (cyc != 3) begin
          errs++;
          $display("FAIL %s first_valid: got cycle %0d want cycle 3", nm, cyc);
        end
      end
      if (ss_tvalid === 1'b1 && ss_tready) begin
        exp_d = mem[(int'(base) / 4 + beat) % 1024];
        exp_l = (beat == len - 1);
        vec++;
        if (beat >= len || ss_tdata !== exp_d || ss_tlast !== exp_l) begin
          errs++;
          $display("FAIL %s beat %0d: got d=%h l=%b want d=%h l=%b (len %0d)",
                   nm, beat, ss_tdata, ss_tlast, exp_d, exp_l, len);
        end
        beat++;
      end
      vec++;
      if (done === 1'b1) begin
        done_seen = 1;
        if (beat != len || busy !== 1'b0 || (mode == 0 && cyc != len + 3)) begin
          errs++;
          $display("FAIL %s done: got beats=%0d busy=%b cyc=%0d want beats=%0d busy=0 cyc=%0d",
                   nm, beat, busy, cyc, len, len + 3);
        end
      end else if (busy !== 1'b1) begin
        errs++;
        $display("FAIL %s busy cyc %0d: got %b want 1", nm, cyc, busy);
      end
      prev_stall = (ss_tvalid === 1'b1) && !ss_tready;
      prev_d     = ss_tdata;
      prev_l     = ss_tlast;
    end
    start = 1'b0;
    if (!done_seen) begin
      vec++; errs++;
      $display("FAIL %s timeout: got no done in %0d cycles want done", nm, budget);
    end
    @(negedge axis_clk);
    #1;
    vec++;
    if (busy !== 1'b0 || done !== 1'b0 || ss_tvalid !== 1'b0) begin
      errs++;
      $display("FAIL %s after_done: got busy=%b done=%b v=%b want 0 0 0", nm, busy, done, ss_tvalid);
    end
    vec++;
    if (addr_log.size() != len) begin
      errs++;
      $display("FAIL %s read_count: got %0d want %0d", nm, addr_log.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_a = 12'(int'(base) + 4 * i);
        vec++;
        if (addr_log[i] !== exp_a) begin
          errs++;
          $display("FAIL %s src_A[%0d]: got %h want %h", nm, i, addr_log[i], exp_a);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    bit exp_done;
    pulse_start(32'd0, 12'h120);
    for (int c = 1; c <= 4; c++) begin
      @(negedge axis_clk);
      #1;
      exp_done = (c == 1);
      vec++;
      if (done !== exp_done || busy !== 1'b0 || ss_tvalid !== 1'b0 || src_EN !== 1'b0) begin
        errs++;
        $display("FAIL zero_len cyc %0d: got done=%b busy=%b v=%b en=%b want done=%b busy=0 v=0 en=0",
                 c, done, busy, ss_tvalid, src_EN, exp_done);
      end
    end
  endtask

  task automatic test_abort();
    int beat = 0;
    int cyc = 0;
    ss_tready = 1'b1;
    pulse_start(32'd600, 12'h000);
    while (beat < 100 && cyc < 400) begin
      @(negedge axis_clk);
      cyc++;
      #1;
      if (ss_tvalid === 1'b1 && ss_tready) beat++;
    end
    vec++;
    if (beat < 100) begin
      errs++;
      $display("FAIL abort_reach: got %0d beats want 100", beat);
    end
    axis_rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, done, src_EN, src_WE, src_A, ss_tvalid, ss_tdata, ss_tlast} !== '0) begin
      errs++;
      $display("FAIL abort_outputs: got busy=%b done=%b en=%b a=%h v=%b d=%h l=%b want all 0",
               busy, done, src_EN, src_A, ss_tvalid, ss_tdata, ss_tlast);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge axis_clk);
      vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    axis_rst_n = 1'b1;
    test_stream("after_abort", 12'h000, 600, 0, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) begin
      t = i % 200;
      mem[i] = 32'((t < 100) ? t * 16 : (200 - t) * 16);
    end
    test_reset();
    test_stream("tri_ready", 12'h000, 600, 0, 0);
    test_stream("tri_pattern", 12'h000, 600, 1, 0);
    mem[16] = 32'h0000_002A;
    test_stream("len1", 12'h040, 1, 0, 0);
    test_zero_len();
    test_stream("wrap", 12'hFFC, 3, 0, 0);
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int r = 0; r < 3; r++) begin
      test_stream("rand_ready", 12'($urandom_range(0, 1023) * 4), $urandom_range(2, 50), 2, 0);
    end
    test_abort();
    test_stream("start_ignored", 12'h100, 20, 0, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
